// File: rtl/syn_global_pkg.sv
// syn_global_pkg: widths shared by every GPU block.
//   P_32B_W  native datapath width
package syn_global_pkg;
  localparam int P_32B_W = 32;
endpackage

// File: rtl/syn_gpu_pkg.sv
// syn_gpu_pkg: mulberry bus types shared by the GPU requesters and the math-unit arbiter.
//   sid_t        request opcode on the mulberry bus (idle / multiply / divide)
//   P_16B_W      operand half width; operands travel as {opA[31:16], opB[15:0]}
//   arb_state_t  arbiter FSM states
package syn_gpu_pkg;
  typedef enum logic [1:0] {
    SID_IDLE = 2'd0,
    SID_MUL  = 2'd1,
    SID_DIV  = 2'd2
  } sid_t;

  localparam int P_16B_W = 16;

  typedef enum logic [1:0] {
    IDLE_S     = 2'd0,
    ISSUE_S    = 2'd1,
    WAIT_RES_S = 2'd2
  } arb_state_t;
endpackage

// File: rtl/syn_rr_arb.sv
// syn_rr_arb: combinational round-robin picker.
//   req      pending vector, one bit per requester
//   ptr      index of the last served requester; search starts at ptr+1
//   gnt_idx  first pending index found searching upward from ptr+1 with wrap
//   gnt_vld  at least one requester pends
module syn_rr_arb #(
  parameter  int P_NUM_REQ = 4,
  localparam int IDX_W     = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1
) (
  input  logic [P_NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_vld
);
  int cand;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    // off runs 1..N so the last served requester is considered last
    for (int off = 1; off <= P_NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % P_NUM_REQ;
      if (!gnt_vld && req[IDX_W'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end
endmodule

// File: rtl/syn_gpu_mulberry_arb.sv
// syn_gpu_mulberry_arb: shares one mulberry math unit between P_NUM_REQ requesters.
// One operation in flight; round-robin grant; result routed back to the owner;
// a watchdog forces an all-ones error result if the math unit never answers.
// Ports:
//   clk_ir, rst_sync            clock, synchronous active-high reset
//   req_sid/req_data            per-requester opcode (2b slices) and operands
//   req_rdy                     1-cycle pulse: request i accepted by the math unit
//   res_valid/res               1-cycle pulse per requester, shared result bus
//   math_sid/math_data/math_rdy request handshake towards the math unit
//   math_res_valid/math_res     math unit result strobe and data
//   timeout_err/timeout_cnt     watchdog expiry pulse and saturating expiry count
module syn_gpu_mulberry_arb
  import syn_global_pkg::*;
  import syn_gpu_pkg::*;
#(
  parameter int P_NUM_REQ = 4,
  parameter int P_DATA_W  = P_32B_W,
  parameter int P_TIMEOUT = 256,
  parameter int P_TOCNT_W = 8
) (
  input  logic                          clk_ir,
  input  logic                          rst_sync,
  input  logic [2*P_NUM_REQ-1:0]        req_sid,
  input  logic [P_DATA_W*P_NUM_REQ-1:0] req_data,
  output logic [P_NUM_REQ-1:0]          req_rdy,
  output logic [P_NUM_REQ-1:0]          res_valid,
  output logic [P_DATA_W-1:0]           res,
  output logic [1:0]                    math_sid,
  output logic [P_DATA_W-1:0]           math_data,
  input  logic                          math_rdy,
  input  logic                          math_res_valid,
  input  logic [P_DATA_W-1:0]           math_res,
  output logic                          timeout_err,
  output logic [P_TOCNT_W-1:0]          timeout_cnt
);
  localparam int IDX_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam int WD_W  = $clog2(P_TIMEOUT);

  logic [P_NUM_REQ-1:0] pend;
  logic [IDX_W-1:0]     rr_idx;
  logic                 rr_vld;
  logic [1:0]           sel_sid;
  logic [P_DATA_W-1:0]  sel_data;

  arb_state_t           state_q,       state_d;
  logic [IDX_W-1:0]     gnt_idx_q,     gnt_idx_d;
  logic [IDX_W-1:0]     ptr_q,         ptr_d;
  sid_t                 math_sid_q,    math_sid_d;
  logic [P_DATA_W-1:0]  math_data_q,   math_data_d;
  logic [P_NUM_REQ-1:0] req_rdy_q,     req_rdy_d;
  logic [P_NUM_REQ-1:0] res_valid_q,   res_valid_d;
  logic [P_DATA_W-1:0]  res_q,         res_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [P_TOCNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [WD_W-1:0]      wd_q,          wd_d;

  for (genvar gi = 0; gi < P_NUM_REQ; gi++) begin : g_pend
    assign pend[gi] = (req_sid[2*gi +: 2] != 2'(SID_IDLE));
  end

  syn_rr_arb #(.P_NUM_REQ(P_NUM_REQ)) u_rr (
    .req     (pend),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Operand mux for the winner; constant slices keep the select width-clean.
  always_comb begin
    sel_sid  = '0;
    sel_data = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (rr_idx == IDX_W'(i)) begin
        sel_sid  = req_sid[2*i +: 2];
        sel_data = req_data[i*P_DATA_W +: P_DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_idx_d     = gnt_idx_q;
    ptr_d         = ptr_q;
    math_sid_d    = math_sid_q;
    math_data_d   = math_data_q;
    req_rdy_d     = '0;
    res_valid_d   = '0;
    res_d         = res_q;
    timeout_err_d = 1'b0;
    timeout_cnt_d = timeout_cnt_q;
    wd_d          = wd_q;
    case (state_q)
      IDLE_S: begin
        if (rr_vld) begin
          // Latch everything now so the requester may drop sid after req_rdy.
          gnt_idx_d   = rr_idx;
          math_sid_d  = sid_t'(sel_sid);
          math_data_d = sel_data;
          state_d     = ISSUE_S;
        end
      end
      ISSUE_S: begin
        if (math_rdy) begin
          req_rdy_d[gnt_idx_q] = 1'b1;
          math_sid_d           = SID_IDLE;
          wd_d                 = '0;
          state_d              = WAIT_RES_S;
        end
      end
      WAIT_RES_S: begin
        // A result arriving in the expiry cycle wins over the watchdog.
        if (math_res_valid) begin
          res_d                  = math_res;
          res_valid_d[gnt_idx_q] = 1'b1;
          ptr_d                  = gnt_idx_q;
          state_d                = IDLE_S;
        end else if (wd_q == WD_W'(P_TIMEOUT - 1)) begin
          res_d                  = '1;
          res_valid_d[gnt_idx_q] = 1'b1;
          timeout_err_d          = 1'b1;
          if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + 1'b1;
          ptr_d                  = gnt_idx_q;
          state_d                = IDLE_S;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state_q       <= IDLE_S;
      gnt_idx_q     <= '0;
      ptr_q         <= IDX_W'(P_NUM_REQ - 1);  // requester 0 wins first
      math_sid_q    <= SID_IDLE;
      math_data_q   <= '0;
      req_rdy_q     <= '0;
      res_valid_q   <= '0;
      res_q         <= '0;
      timeout_err_q <= 1'b0;
      timeout_cnt_q <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      gnt_idx_q     <= gnt_idx_d;
      ptr_q         <= ptr_d;
      math_sid_q    <= math_sid_d;
      math_data_q   <= math_data_d;
      req_rdy_q     <= req_rdy_d;
      res_valid_q   <= res_valid_d;
      res_q         <= res_d;
      timeout_err_q <= timeout_err_d;
      timeout_cnt_q <= timeout_cnt_d;
      wd_q          <= wd_d;
    end
  end

  assign req_rdy     = req_rdy_q;
  assign res_valid   = res_valid_q;
  assign res         = res_q;
  assign math_sid    = math_sid_q;
  assign math_data   = math_data_q;
  assign timeout_err = timeout_err_q;
  assign timeout_cnt = timeout_cnt_q;
endmodule
